// File: rtl/gfg_spi_register_slave_if.sv
// gfg_spi_register_slave_if: SPI pins and register-file port of the SPI register slave
//   i_spi_clk/i_spi_mosi/i_spi_ss_n : SPI master to slave (mode 3, MSB first)
//   o_spi_miso                      : SPI slave to master
//   o_reg_addr/o_reg_write_data/o_reg_write_en : register RAM write port, addr also drives the read port
//   i_reg_read_data                 : register RAM read data, 1 cycle after o_reg_addr
//   slave modport for the register slave, master modport for the SPI master / RAM side
interface gfg_spi_register_slave_if #(
   parameter int NUM_REGISTERS  = 32,
   parameter int REGISTER_WIDTH = 32
);
   localparam int AW = $clog2(NUM_REGISTERS);
   logic                      i_spi_clk;
   logic                      i_spi_mosi;
   logic                      i_spi_ss_n;
   logic                      o_spi_miso;
   logic [AW-1:0]             o_reg_addr;
   logic [REGISTER_WIDTH-1:0] o_reg_write_data;
   logic                      o_reg_write_en;
   logic [REGISTER_WIDTH-1:0] i_reg_read_data;
   modport slave (
      input  i_spi_clk, i_spi_mosi, i_spi_ss_n, i_reg_read_data,
      output o_spi_miso, o_reg_addr, o_reg_write_data, o_reg_write_en
   );
   modport master (
      output i_spi_clk, i_spi_mosi, i_spi_ss_n, i_reg_read_data,
      input  o_spi_miso, o_reg_addr, o_reg_write_data, o_reg_write_en
   );
endinterface

// File: rtl/gfg_spi_register_slave.sv
// gfg_spi_register_slave: SPI mode-3 slave giving read/write access to a register bank
//   i_sys_clk : system clock, rising edge
//   i_srst_n  : asynchronous active-low reset
//   bus       : SPI pins and register-file port (slave modport)
module gfg_spi_register_slave #(
   parameter int NUM_REGISTERS  = 32,
   parameter int REGISTER_WIDTH = 32
) (
   input logic                     i_sys_clk,
   input logic                     i_srst_n,
   gfg_spi_register_slave_if.slave bus
);
   localparam int AW = $clog2(NUM_REGISTERS);
   localparam int RW = REGISTER_WIDTH;
   localparam int CW = $clog2(RW + 1);
   typedef enum logic [1:0] {IDLE, CMD, WRITE_DATA, READ_DATA} state_t;
   state_t        state, state_n;
   logic [1:0]    sclk_s, mosi_s, ss_s, cap, cap_n;
   logic          sclk_d, armed, armed_n, rise, fall, ss_hi, ld;
   logic          we, we_n, miso, miso_n;
   logic [CW-1:0] shift_register_tracker, cnt_n;
   logic [RW-1:0] spi_mosi_shift_register, sr_n, sh, tx, tx_n, wd, wd_n;
   logic [AW-1:0] addr, addr_n;

   assign rise  = sclk_s[1] & ~sclk_d;
   assign fall  = ~sclk_s[1] & sclk_d;
   assign ss_hi = ss_s[1];
   assign sh    = {spi_mosi_shift_register[RW-2:0], mosi_s[1]};

   assign bus.o_reg_addr       = addr;
   assign bus.o_reg_write_data = wd;
   assign bus.o_reg_write_en   = we;
   assign bus.o_spi_miso       = miso;

   always_ff @(posedge i_sys_clk or negedge i_srst_n)
      if (!i_srst_n) begin
         sclk_s                  <= '0;
         mosi_s                  <= '0;
         ss_s                    <= '0;
         sclk_d                  <= 1'b0;
         armed                   <= 1'b0;
         state                   <= IDLE;
         shift_register_tracker  <= '0;
         spi_mosi_shift_register <= '0;
         tx                      <= '0;
         wd                      <= '0;
         we                      <= 1'b0;
         addr                    <= '0;
         miso                    <= 1'b0;
         cap                     <= '0;
      end else begin
         sclk_s                  <= {sclk_s[0], bus.i_spi_clk};
         mosi_s                  <= {mosi_s[0], bus.i_spi_mosi};
         ss_s                    <= {ss_s[0], bus.i_spi_ss_n};
         sclk_d                  <= sclk_s[1];
         armed                   <= armed_n;
         state                   <= state_n;
         shift_register_tracker  <= cnt_n;
         spi_mosi_shift_register <= sr_n;
         tx                      <= tx_n;
         wd                      <= wd_n;
         we                      <= we_n;
         addr                    <= addr_n;
         miso                    <= miso_n;
         cap                     <= cap_n;
      end

   // armed blocks any activity after reset until slave select has been seen high,
   // so a selection already in progress at reset release is ignored.
   // cap delays the read-data capture until the RAM output reflects the new address.
   always_comb begin
      state_n = state;
      cnt_n   = shift_register_tracker;
      sr_n    = spi_mosi_shift_register;
      addr_n  = addr;
      wd_n    = wd;
      we_n    = 1'b0;
      ld      = 1'b0;
      miso_n  = miso;
      armed_n = armed | ss_hi;
      tx_n    = cap[1] ? bus.i_reg_read_data : tx;
      if (ss_hi) begin
         if (shift_register_tracker[2:0] != 3'd0) begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      end else if (armed) begin
         case (state)
            IDLE: if (rise | fall) begin
               state_n = CMD;
               cnt_n   = CW'(rise);
               sr_n    = rise ? sh : spi_mosi_shift_register;
            end
            CMD: if (rise) begin
               sr_n  = sh;
               cnt_n = shift_register_tracker + CW'(1);
               if (shift_register_tracker == CW'(7)) begin
                  cnt_n   = '0;
                  ld      = sh[7] ^ sh[6];
                  state_n = sh[7:6] == 2'b10 ? WRITE_DATA : sh[7:6] == 2'b01 ? READ_DATA : IDLE;
                  addr_n  = ld ? sh[AW-1:0] : addr;
               end
            end
            WRITE_DATA: if (rise) begin
               sr_n  = sh;
               cnt_n = shift_register_tracker + CW'(1);
               if (shift_register_tracker == CW'(RW - 1)) begin
                  cnt_n   = '0;
                  state_n = IDLE;
                  wd_n    = sh;
                  we_n    = 1'b1;
               end
            end
            default: if (rise) begin
               cnt_n = shift_register_tracker + CW'(1);
               if (shift_register_tracker == CW'(RW - 1)) begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end else if (fall) begin
               miso_n = tx[RW-1];
               tx_n   = {tx[RW-2:0], 1'b0};
            end
         endcase
      end
      cap_n = {cap[0], ld & (state_n == READ_DATA)};
      if (state_n != READ_DATA) miso_n = 1'b0;
   end
endmodule

// File: tb/tb_gfg_spi_register_slave.sv
// tb_gfg_spi_register_slave: scoreboard bench for the SPI register slave with a 1-cycle-read RAM model
module tb_gfg_spi_register_slave;
   localparam int HP = 60;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [36:0] exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [36:0] wr_e;
   logic [31:0] rd_w = '0;
   int rd_n = 0;
   logic rd_active = 1'b0;
   logic chk_zero = 1'b0;
   logic [31:0] mem [32];

   always #5 clk = ~clk;

   gfg_spi_register_slave_if #(.NUM_REGISTERS(32), .REGISTER_WIDTH(32)) bus ();
   gfg_spi_register_slave #(.NUM_REGISTERS(32), .REGISTER_WIDTH(32)) dut (
      .i_sys_clk(clk),
      .i_srst_n(rst_n),
      .bus(bus)
   );

   always @(posedge clk) begin
      if (bus.o_reg_write_en) mem[bus.o_reg_addr] <= bus.o_reg_write_data;
      bus.i_reg_read_data <= mem[bus.o_reg_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rst_n && bus.o_reg_write_en) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %h expected no write", bus.o_reg_addr, bus.o_reg_write_data);
         end else begin
            wr_e = exp_wr.pop_front();
            check("write_addr", 32'(bus.o_reg_addr), 32'(wr_e[36:32]));
            check("write_data", bus.o_reg_write_data, wr_e[31:0]);
         end
      end

   always @(posedge bus.i_spi_clk) begin
      if (chk_zero) check("miso_quiet", 32'(bus.o_spi_miso), 32'd0);
      if (rd_active) begin
         rd_w = {rd_w[30:0], bus.o_spi_miso};
         rd_n++;
         if (rd_n == 32) begin
            rd_n = 0;
            if (exp_rd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: got %h expected no read", rd_w);
            end else check("read_data", rd_w, exp_rd.pop_front());
         end
      end
   end

   task automatic bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_spi_clk  = 1'b0;
         bus.i_spi_mosi = b[7-i];
         #HP;
         bus.i_spi_clk = 1'b1;
         #HP;
      end
   endtask

   task automatic sel(input logic v);
      bus.i_spi_ss_n = ~v;
      #HP;
   endtask

   task automatic xfer(input logic [7:0] cmd, input logic [31:0] data, input logic pause, input logic rd);
      sel(1'b1);
      bits(cmd, 8);
      rd_active = rd;
      for (int k = 0; k < 4; k++) begin
         if (pause) begin
            sel(1'b0);
            sel(1'b1);
         end
         bits(data[31-8*k -: 8], 8);
      end
      rd_active = 1'b0;
      sel(1'b0);
   endtask

   task automatic outputs_zero(input string tag);
      check({tag, "_addr"}, 32'(bus.o_reg_addr), 32'd0);
      check({tag, "_wdata"}, bus.o_reg_write_data, 32'd0);
      check({tag, "_we"}, 32'(bus.o_reg_write_en), 32'd0);
      check({tag, "_miso"}, 32'(bus.o_spi_miso), 32'd0);
   endtask

   initial begin
      bus.i_spi_clk  = 1'b1;
      bus.i_spi_ss_n = 1'b1;
      bus.i_spi_mosi = 1'b0;
      #100;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      outputs_zero("reset");

      exp_wr.push_back({5'd0, 32'h04030201});
      xfer(8'h80, 32'h04030201, 1'b0, 1'b0);
      exp_wr.push_back({5'd31, 32'h01020304});
      xfer(8'h9F, 32'h01020304, 1'b1, 1'b0);

      sel(1'b1);
      bits(8'h8A, 8);
      bits(8'hFF, 5);
      sel(1'b0);
      check("abort_data_addr", 32'(bus.o_reg_addr), 32'd10);
      sel(1'b1);
      bits(8'h80, 7);
      sel(1'b0);
      check("abort_cmd_addr", 32'(bus.o_reg_addr), 32'd10);
      sel(1'b1);
      bits(8'h40, 8);
      bits(8'h00, 8);
      bits(8'h00, 7);
      sel(1'b0);
      check("abort_read_addr", 32'(bus.o_reg_addr), 32'd0);
      check("abort_read_miso", 32'(bus.o_spi_miso), 32'd0);

      exp_rd.push_back(32'h04030201);
      xfer(8'h40, 32'h0, 1'b0, 1'b1);
      exp_rd.push_back(32'h01020304);
      xfer(8'h5F, 32'h0, 1'b1, 1'b1);

      chk_zero = 1'b1;
      sel(1'b1);
      bits(8'h00, 8);
      sel(1'b0);
      check("nop00_addr", 32'(bus.o_reg_addr), 32'd31);
      sel(1'b1);
      bits(8'h1F, 8);
      sel(1'b0);
      check("nop1f_addr", 32'(bus.o_reg_addr), 32'd31);
      sel(1'b1);
      bits(8'hDF, 8);
      bits(8'h00, 8);
      sel(1'b0);
      check("invalid_addr", 32'(bus.o_reg_addr), 32'd31);
      chk_zero = 1'b0;

      sel(1'b1);
      bits(8'h95, 5);
      rst_n = 1'b0;
      bits(8'hA0, 3);
      rst_n = 1'b1;
      bits(8'h9F, 8);
      sel(1'b0);
      repeat (3) @(negedge clk);
      outputs_zero("mid_reset");

      exp_wr.push_back({5'd31, 32'h25262728});
      xfer(8'h9F, 32'h25262728, 1'b0, 1'b0);
      exp_rd.push_back(32'h25262728);
      xfer(8'h5F, 32'h0, 1'b0, 1'b1);

      repeat (20) @(negedge clk);
      check("writes_pending", 32'(exp_wr.size()), 32'd0);
      check("reads_pending", 32'(exp_rd.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
